// File: rtl/instruction_fetch_stage_pkg.sv
// Shared CPU constants and the IF/ID payload type for the 16-bit five-stage pipeline.
package instruction_fetch_stage_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 16;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus_one;
    logic               valid;
  } if_id_t;

  // Modulo-2^16 increment used for both the PC and the IF/ID pcPlusOne field.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return ADDR_W'(pc + ADDR_W'(1));
  endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_register.sv
// IF/ID pipeline register: load a fetched payload, insert a bubble, or hold.
module if_id_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = instruction_fetch_stage_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t payload_i,
  output if_id_t if_id_o
);

  if_id_t if_id_d;
  if_id_t if_id_q;

  // Bubble keeps the previous pcPlusOne; it only replaces the instruction and clears valid.
  always_comb begin
    if_id_d = if_id_q;
    if (bubble_i) begin
      if_id_d.instr = NOP_INSTR;
      if_id_d.valid = 1'b0;
    end else if (load_i) begin
      if_id_d = payload_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q.instr       <= NOP_INSTR;
      if_id_q.pc_plus_one <= '0;
      if_id_q.valid       <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: PC, instruction-memory request, hazard priority decode and bubble counter.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = instruction_fetch_stage_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = instruction_fetch_stage_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               branchTaken,
  input  logic [ADDR_W-1:0]  branchTarget,
  input  logic               memBusy,
  output logic [ADDR_W-1:0]  imemAddr,
  output logic               imemRead,
  input  logic [INSTR_W-1:0] imemData,
  output logic [INSTR_W-1:0] instructionOut,
  output logic [ADDR_W-1:0]  pcPlusOneOut,
  output logic               validOut,
  output logic [15:0]        bubbleCountOut
);

  localparam int unsigned CNT_W = 16;

  logic [ADDR_W-1:0] pc_d, pc_q;
  logic [CNT_W-1:0]  bubble_cnt_d, bubble_cnt_q;
  logic              load_c;
  logic              bubble_c;
  if_id_t            payload_c;
  if_id_t            if_id;

  // Priority: branch > stall > flush > memBusy > normal fetch (reset handled in the flops).
  always_comb begin
    pc_d     = pc_q;
    load_c   = 1'b0;
    bubble_c = 1'b0;
    if (branchTaken) begin
      pc_d     = branchTarget;
      bubble_c = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (flush) begin
      bubble_c = 1'b1;
      if (!memBusy) pc_d = pc_inc(pc_q);
    end else if (memBusy) begin
      bubble_c = 1'b1;
    end else begin
      load_c = 1'b1;
      pc_d   = pc_inc(pc_q);
    end
  end

  always_comb begin
    payload_c.instr       = imemData;
    payload_c.pc_plus_one = pc_inc(pc_q);
    payload_c.valid       = 1'b1;
  end

  // Saturating bubble counter.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble_c && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = CNT_W'(bubble_cnt_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      bubble_cnt_q <= '0;
    end else begin
      pc_q         <= pc_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load_c),
    .bubble_i  (bubble_c),
    .payload_i (payload_c),
    .if_id_o   (if_id)
  );

  assign imemAddr       = pc_q;
  assign imemRead       = !rst && !memBusy && !stall;
  assign instructionOut = if_id.instr;
  assign pcPlusOneOut   = if_id.pc_plus_one;
  assign validOut       = if_id.valid;
  assign bubbleCountOut = bubble_cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        mem_busy;
  logic [15:0] imem_addr;
  logic        imem_read;
  logic [15:0] imem_data;
  logic [15:0] instruction_out;
  logic [15:0] pc_plus_one_out;
  logic        valid_out;
  logic [15:0] bubble_count_out;

  int checks = 0;
  int errors = 0;

  instruction_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .branchTaken    (branch_taken),
    .branchTarget   (branch_target),
    .memBusy        (mem_busy),
    .imemAddr       (imem_addr),
    .imemRead       (imem_read),
    .imemData       (imem_data),
    .instructionOut (instruction_out),
    .pcPlusOneOut   (pc_plus_one_out),
    .validOut       (valid_out),
    .bubbleCountOut (bubble_count_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
    branch_target = 16'h0000; mem_busy = 1'b0; imem_data = 16'h0000;
    step();
    checks++;
    if (instruction_out !== 16'h0800 || pc_plus_one_out !== 16'h0000 || valid_out !== 1'b0 ||
        bubble_count_out !== 16'h0000 || imem_addr !== 16'h0000 || imem_read !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: instr=%h pcp1=%h valid=%b cnt=%h addr=%h rd=%b, want 0800 0000 0 0000 0000 0",
               instruction_out, pc_plus_one_out, valid_out, bubble_count_out, imem_addr, imem_read);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_read: imemRead=%b want 1", imem_read);
    end
  endtask

  task automatic test_free_run();
    imem_data = 16'h4801; step();
    checks++;
    if (instruction_out !== 16'h4801 || pc_plus_one_out !== 16'h0001 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL free_run_latency: instr=%h pcp1=%h valid=%b want 4801 0001 1",
               instruction_out, pc_plus_one_out, valid_out);
    end
    imem_data = 16'h4902; step();
    imem_data = 16'h4A03; step();
    checks++;
    if (instruction_out !== 16'h4A03 || pc_plus_one_out !== 16'h0003 || valid_out !== 1'b1 ||
        bubble_count_out !== 16'h0000 || imem_addr !== 16'h0003) begin
      errors++;
      $display("FAIL free_run: instr=%h pcp1=%h valid=%b cnt=%h addr=%h want 4A03 0003 1 0000 0003",
               instruction_out, pc_plus_one_out, valid_out, bubble_count_out, imem_addr);
    end
  endtask

  task automatic test_stall();
    imem_data = 16'h0003; step();
    imem_data = 16'h0004; step();
    stall = 1'b1; imem_data = 16'hDEAD;
    #1;
    checks++;
    if (imem_read !== 1'b0 || imem_addr !== 16'h0005) begin
      errors++;
      $display("FAIL stall_read: rd=%b addr=%h want 0 0005", imem_read, imem_addr);
    end
    step(); step();
    checks++;
    if (imem_addr !== 16'h0005 || instruction_out !== 16'h0004 || pc_plus_one_out !== 16'h0005 ||
        valid_out !== 1'b1 || bubble_count_out !== 16'h0000) begin
      errors++;
      $display("FAIL stall_hold: addr=%h instr=%h pcp1=%h valid=%b cnt=%h want 0005 0004 0005 1 0000",
               imem_addr, instruction_out, pc_plus_one_out, valid_out, bubble_count_out);
    end
    stall = 1'b0; imem_data = 16'h5555; step();
    checks++;
    if (instruction_out !== 16'h5555 || pc_plus_one_out !== 16'h0006 || imem_addr !== 16'h0006) begin
      errors++;
      $display("FAIL stall_resume: instr=%h pcp1=%h addr=%h want 5555 0006 0006",
               instruction_out, pc_plus_one_out, imem_addr);
    end
  endtask

  task automatic test_mem_busy();
    imem_data = 16'h0006; step();
    mem_busy = 1'b1; imem_data = 16'hDEAD;
    #1;
    checks++;
    if (imem_read !== 1'b0 || imem_addr !== 16'h0007) begin
      errors++;
      $display("FAIL busy_read: rd=%b addr=%h want 0 0007", imem_read, imem_addr);
    end
    step();
    checks++;
    if (instruction_out !== 16'h0800 || valid_out !== 1'b0 || pc_plus_one_out !== 16'h0007 ||
        imem_addr !== 16'h0007 || bubble_count_out !== 16'h0001) begin
      errors++;
      $display("FAIL busy_bubble: instr=%h valid=%b pcp1=%h addr=%h cnt=%h want 0800 0 0007 0007 0001",
               instruction_out, valid_out, pc_plus_one_out, imem_addr, bubble_count_out);
    end
    mem_busy = 1'b0; imem_data = 16'h7777; step();
    checks++;
    if (instruction_out !== 16'h7777 || pc_plus_one_out !== 16'h0008 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL busy_resume: instr=%h pcp1=%h valid=%b want 7777 0008 1",
               instruction_out, pc_plus_one_out, valid_out);
    end
  endtask

  task automatic test_branch_override();
    branch_taken = 1'b1; branch_target = 16'h0040; stall = 1'b1; mem_busy = 1'b1;
    step();
    checks++;
    if (imem_addr !== 16'h0040 || instruction_out !== 16'h0800 || valid_out !== 1'b0 ||
        pc_plus_one_out !== 16'h0008 || bubble_count_out !== 16'h0002) begin
      errors++;
      $display("FAIL branch_override: addr=%h instr=%h valid=%b pcp1=%h cnt=%h want 0040 0800 0 0008 0002",
               imem_addr, instruction_out, valid_out, pc_plus_one_out, bubble_count_out);
    end
    stall = 1'b0; mem_busy = 1'b0;
    step();
    checks++;
    if (imem_addr !== 16'h0040 || bubble_count_out !== 16'h0003 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL branch_same_pc: addr=%h cnt=%h valid=%b want 0040 0003 0",
               imem_addr, bubble_count_out, valid_out);
    end
    branch_taken = 1'b0;
  endtask

  task automatic test_flush();
    flush = 1'b1; imem_data = 16'hDEAD; step();
    checks++;
    if (imem_addr !== 16'h0041 || instruction_out !== 16'h0800 || valid_out !== 1'b0 ||
        bubble_count_out !== 16'h0004) begin
      errors++;
      $display("FAIL flush_advance: addr=%h instr=%h valid=%b cnt=%h want 0041 0800 0 0004",
               imem_addr, instruction_out, valid_out, bubble_count_out);
    end
    mem_busy = 1'b1; step();
    checks++;
    if (imem_addr !== 16'h0041 || bubble_count_out !== 16'h0005) begin
      errors++;
      $display("FAIL flush_busy: addr=%h cnt=%h want 0041 0005", imem_addr, bubble_count_out);
    end
    mem_busy = 1'b0; stall = 1'b1; step();
    checks++;
    if (imem_addr !== 16'h0041 || bubble_count_out !== 16'h0005) begin
      errors++;
      $display("FAIL flush_stalled: addr=%h cnt=%h want 0041 0005", imem_addr, bubble_count_out);
    end
    stall = 1'b0; flush = 1'b0; imem_data = 16'h1234; step();
    checks++;
    if (instruction_out !== 16'h1234 || pc_plus_one_out !== 16'h0042 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_not_remembered: instr=%h pcp1=%h valid=%b want 1234 0042 1",
               instruction_out, pc_plus_one_out, valid_out);
    end
  endtask

  task automatic test_wrap();
    branch_taken = 1'b1; branch_target = 16'hFFFF; step();
    branch_taken = 1'b0; imem_data = 16'hBEEF; step();
    checks++;
    if (instruction_out !== 16'hBEEF || pc_plus_one_out !== 16'h0000 || imem_addr !== 16'h0000 ||
        valid_out !== 1'b1 || bubble_count_out !== 16'h0006) begin
      errors++;
      $display("FAIL pc_wrap: instr=%h pcp1=%h addr=%h valid=%b cnt=%h want BEEF 0000 0000 1 0006",
               instruction_out, pc_plus_one_out, imem_addr, valid_out, bubble_count_out);
    end
  endtask

  task automatic test_saturation();
    mem_busy = 1'b1;
    repeat (65528) @(posedge clk);
    #1;
    checks++;
    if (bubble_count_out !== 16'hFFFE || imem_addr !== 16'h0000) begin
      errors++;
      $display("FAIL sat_pre: cnt=%h addr=%h want FFFE 0000", bubble_count_out, imem_addr);
    end
    step();
    checks++;
    if (bubble_count_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach: cnt=%h want FFFF", bubble_count_out);
    end
    step(); step(); step();
    checks++;
    if (bubble_count_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: cnt=%h want FFFF", bubble_count_out);
    end
    mem_busy = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    imem_data = 16'h2222; step();
    stall = 1'b1; rst = 1'b1; step();
    checks++;
    if (imem_addr !== 16'h0000 || instruction_out !== 16'h0800 || valid_out !== 1'b0 ||
        pc_plus_one_out !== 16'h0000 || bubble_count_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_stall: addr=%h instr=%h valid=%b pcp1=%h cnt=%h want 0000 0800 0 0000 0000",
               imem_addr, instruction_out, valid_out, pc_plus_one_out, bubble_count_out);
    end
    stall = 1'b0; rst = 1'b0; imem_data = 16'h3333; step();
    checks++;
    if (instruction_out !== 16'h3333 || pc_plus_one_out !== 16'h0001 || imem_addr !== 16'h0001) begin
      errors++;
      $display("FAIL reset_restart: instr=%h pcp1=%h addr=%h want 3333 0001 0001",
               instruction_out, pc_plus_one_out, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_mem_busy();
    test_branch_override();
    test_flush();
    test_wrap();
    test_saturation();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
